sub4_result_stage: RTL and testbench

Registered output stage directly downstream of the 4-bit combinational subtractor. It captures the operands and the subtractor's result, carry and overflow through a valid/ready handshake, and buffers up to two results. It derives zero and negative flags, keeps a sticky overflow flag and a completed-operation counter, and presents everything to the consumer with backpressure.

---
 rtl/sub4_pkg.sv | 23 ++
 rtl/sub4_fifo2.sv | 76 +++++++
 rtl/sub4_result_stage.sv | 109 ++++++++++
 tb/tb_sub4_result_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub4_pkg.sv
// Shared types and constants for the 4-bit subtractor result stage.
package sub4_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [3:0] result;
        logic       co;
        logic       ovf;
        logic       zero;
        logic       neg;
    } sub4_entry_t;

    localparam int ENTRY_W = $bits(sub4_entry_t);

    localparam logic [3:0] SAT_POS = 4'b0111;
    localparam logic [3:0] SAT_NEG = 4'b1000;

endpackage

// File: rtl/sub4_fifo2.sv
// Two-entry strict-FIFO buffer with EMPTY/ONE/TWO occupancy FSM.
// Handshake outputs are registered and depend only on occupancy.
module sub4_fifo2
    import sub4_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [ENTRY_W-1:0] i_data,
    output logic               o_in_ready,
    output logic               o_out_valid,
    output logic [ENTRY_W-1:0] o_data
);

    occ_state_t         r_state;
    logic [ENTRY_W-1:0] r_head;
    logic [ENTRY_W-1:0] r_tail;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_push & r_in_ready;
    assign w_pop  = i_pop & r_out_valid;

    // Head always holds the oldest entry; tail is only occupied in TWO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_head      <= i_data;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= i_data;
                    end else if (w_push) begin
                        r_tail     <= i_data;
                        r_state    <= TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_pop) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_head     <= r_tail;
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_data      = r_head;

endmodule

// File: rtl/sub4_result_stage.sv
// Registered result stage after the 4-bit subtractor: flags, sticky overflow, op counter.
// Optional saturation of overflowed results is enabled by defining SUB4_SATURATE_EN.
module sub4_result_stage
    import sub4_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_n1,
    input  logic [3:0]       in_n2,
    input  logic [3:0]       in_result,
    input  logic             in_co,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_result,
    output logic             out_co,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

`ifdef SUB4_SATURATE_EN
    // Signed overflow in a - b can only happen when signs differ, so a's sign picks the rail.
    function automatic logic [3:0] saturate(input logic n1_msb, input logic [3:0] res,
                                            input logic ovf);
        if (ovf)
            return n1_msb ? SAT_NEG : SAT_POS;
        return res;
    endfunction
`endif

    logic [3:0]       w_store_result;
    sub4_entry_t      w_wr_entry;
    sub4_entry_t      w_head;
    logic [ENTRY_W-1:0] w_head_bits;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_unused_ops;
    logic             r_sticky;
    logic [CNT_W-1:0] r_op_count;

`ifdef SUB4_SATURATE_EN
    assign w_store_result = saturate(in_n1[3], in_result, in_ovf);
`else
    assign w_store_result = in_result;
`endif

    // Operands are only consumed by the optional saturation path.
    assign w_unused_ops = ^{in_n1, in_n2};

    always_comb begin
        w_wr_entry        = '0;
        w_wr_entry.result = w_store_result;
        w_wr_entry.co     = in_co;
        w_wr_entry.ovf    = in_ovf;
        w_wr_entry.zero   = (w_store_result == 4'b0000);
        w_wr_entry.neg    = w_store_result[3];
    end

    sub4_fifo2 u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (in_valid),
        .i_pop       (out_ready),
        .i_data      (w_wr_entry),
        .o_in_ready  (w_in_ready),
        .o_out_valid (w_out_valid),
        .o_data      (w_head_bits)
    );

    assign w_head = sub4_entry_t'(w_head_bits);
    assign w_push = in_valid & w_in_ready;
    assign w_pop  = w_out_valid & out_ready;

    // Set has priority over a same-cycle clear so no overflow event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky   <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_push && in_ovf)
                r_sticky <= 1'b1;
            else if (clr_sticky)
                r_sticky <= 1'b0;
            if (w_pop)
                r_op_count <= r_op_count + 1'b1;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_result = w_head.result;
    assign out_co     = w_head.co;
    assign out_ovf    = w_head.ovf;
    assign out_zero   = w_head.zero;
    assign out_neg    = w_head.neg;
    assign sticky_ovf = r_sticky;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_sub4_result_stage.sv
// Self-checking bench for sub4_result_stage: vector table plus scoreboard-driven corner sequences.
module tb_sub4_result_stage;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [3:0] res;
        logic       co;
        logic       ovf;
        logic       zero;
        logic       neg;
    } exp_t;

    typedef struct {
        logic [3:0] n1;
        logic [3:0] n2;
        logic [3:0] res;
        logic       co;
        logic       ovf;
        logic [3:0] e_wrap;
        logic [3:0] e_sat;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_n1 = '0;
    logic [3:0]       in_n2 = '0;
    logic [3:0]       in_result = '0;
    logic             in_co = 1'b0;
    logic             in_ovf = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_result;
    logic             out_co;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;
    logic             sticky_ovf;
    logic             clr_sticky = 1'b0;
    logic [CNT_W-1:0] op_count;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t drv_exp = '0;
    exp_t q[$];
    logic m_sticky = 1'b0;
    logic [CNT_W-1:0] m_count = '0;
    vec_t vecs[8];

    sub4_result_stage #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_n1      (in_n1),
        .in_n2      (in_n2),
        .in_result  (in_result),
        .in_co      (in_co),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_co     (out_co),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [3:0] r, input logic co, input logic ovf);
        exp_t e;
        e.res  = r;
        e.co   = co;
        e.ovf  = ovf;
        e.zero = (r == 4'b0000);
        e.neg  = r[3];
        return e;
    endfunction

    // Scoreboard: samples one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            q.delete();
            m_sticky = 1'b0;
            m_count  = '0;
        end else begin
            check("in_ready", in_ready, (q.size() < 2));
            check("out_valid", out_valid, (q.size() > 0));
            check("sticky_ovf", sticky_ovf, m_sticky);
            check("op_count", op_count, m_count);
            if (out_valid && q.size() > 0)
                check("head_entry", {out_result, out_co, out_ovf, out_zero, out_neg}, q[0]);
            if (out_valid && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                m_count = m_count + 1'b1;
            end
            if (in_valid && in_ready) begin
                q.push_back(drv_exp);
                if (in_ovf) m_sticky = 1'b1;
                else if (clr_sticky) m_sticky = 1'b0;
            end else if (clr_sticky) begin
                m_sticky = 1'b0;
            end
        end
    end

    task automatic send_raw(input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] r,
                            input logic co, input logic ovf, input exp_t e);
        logic acc;
        acc       = 1'b0;
        in_valid  = 1'b1;
        in_n1     = n1;
        in_n2     = n2;
        in_result = r;
        in_co     = co;
        in_ovf    = ovf;
        drv_exp   = e;
        for (int w = 0; w < 20 && !acc; w++) begin
            #4;
            acc = in_ready;
            @(negedge clk);
        end
        if (!acc) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Reference arithmetic for a 4-bit two's-complement subtractor feeding the stage.
    task automatic send_op(input logic [3:0] n1, input logic [3:0] n2);
        logic [3:0] r;
        logic [3:0] s;
        logic       co;
        logic       ovf;
        r   = n1 - n2;
        co  = ({1'b0, n1} >= {1'b0, n2});
        ovf = (n1[3] != n2[3]) && (r[3] != n1[3]);
        s   = r;
`ifdef SUB4_SATURATE_EN
        if (ovf) s = n1[3] ? 4'b1000 : 4'b0111;
`endif
        send_raw(n1, n2, r, co, ovf, mk_exp(s, co, ovf));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_n1     = 4'($urandom);
            in_n2     = 4'($urandom);
            in_result = 4'($urandom);
            in_co     = 1'($urandom);
            in_ovf    = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic wait_empty();
        int w;
        w = 0;
        while (out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", out_valid, 0);
    endtask

    initial begin
        logic [3:0] er;
        vecs[0] = '{4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0010};
        vecs[1] = '{4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000};
        vecs[2] = '{4'b0010, 4'b0101, 4'b1101, 1'b0, 1'b0, 4'b1101, 4'b1101};
        vecs[3] = '{4'b0111, 4'b1111, 4'b1000, 1'b0, 1'b1, 4'b1000, 4'b0111};
        vecs[4] = '{4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1, 4'b0111, 4'b1000};
        vecs[5] = '{4'b1111, 4'b0111, 4'b1000, 1'b1, 1'b0, 4'b1000, 4'b1000};
        vecs[6] = '{4'b0100, 4'b1100, 4'b1000, 1'b0, 1'b1, 4'b1000, 4'b0111};
        vecs[7] = '{4'b0110, 4'b0001, 4'b0101, 1'b1, 1'b0, 4'b0101, 4'b0101};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {out_result, out_co, out_ovf, out_zero, out_neg}, 0);
        check("rst_sticky", sticky_ovf, 0);
        check("rst_op_count", op_count, 0);
        rst_n = 1'b1;
        idle(2);

        // Table vectors, streaming with out_ready high
        out_ready = 1'b1;
        foreach (vecs[i]) begin
`ifdef SUB4_SATURATE_EN
            er = vecs[i].e_sat;
`else
            er = vecs[i].e_wrap;
`endif
            send_raw(vecs[i].n1, vecs[i].n2, vecs[i].res, vecs[i].co, vecs[i].ovf,
                     mk_exp(er, vecs[i].co, vecs[i].ovf));
        end
        wait_empty();
        check("table_op_count", op_count, 8);
        check("table_sticky", sticky_ovf, 1);

        clr_sticky = 1'b1;
        idle(1);
        clr_sticky = 1'b0;
        check("clr_sticky", sticky_ovf, 0);

        // Backpressure: third entry must wait for space
        out_ready = 1'b0;
        send_op(4'd1, 4'd1);
        send_op(4'd6, 4'd2);
        check("bp_in_ready_low", in_ready, 0);
        fork
            send_op(4'b1001, 4'd3);
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_empty();
        check("bp_queue_empty", q.size(), 0);

        // Overflow with simultaneous clear: set wins
        send_op(4'b0111, 4'b1111);
        check("ovf_sticky", sticky_ovf, 1);
        clr_sticky = 1'b1;
        send_op(4'b1000, 4'b0001);
        clr_sticky = 1'b0;
        check("set_wins_sticky", sticky_ovf, 1);
        wait_empty();

        // Reset with two entries buffered
        out_ready = 1'b0;
        send_op(4'd2, 4'd1);
        send_op(4'b0100, 4'b1100);
        check("two_buffered", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_outputs", {out_result, out_co, out_ovf, out_zero, out_neg}, 0);
        check("mrst_sticky", sticky_ovf, 0);
        check("mrst_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Counter wrap: 17 releases on a 4-bit counter
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++)
            send_op(4'($urandom), 4'($urandom));
        wait_empty();
        check("wrap_op_count", op_count, 1);
        idle(2);
        check("final_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
